// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back result select, 32x32 register file with write-through read ports
module wb_regfile #(
    parameter int DATA_WIDTH             = 32,
    parameter int REGISTER_ADDRESS_WIDTH = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              RegWriteW,
    input  logic [1:0]                        ResultSrcW,
    input  logic [DATA_WIDTH-1:0]             ALUResultW,
    input  logic [DATA_WIDTH-1:0]             ReadDataW,
    input  logic [DATA_WIDTH-1:0]             ImmExtW,
    input  logic [DATA_WIDTH-1:0]             PCPlus4W,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] A1D,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] A2D,
    output logic [DATA_WIDTH-1:0]             ResultW,
    output logic [DATA_WIDTH-1:0]             RD1D,
    output logic [DATA_WIDTH-1:0]             RD2D,
    output logic [DATA_WIDTH-1:0]             a0,
    output logic [31:0]                       CommitCount
);
    localparam int NUM_REGS = 1 << REGISTER_ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [31:0]           r_commit_count;
    logic                  w_commit;

    always_comb begin
        ResultW = ALUResultW;
        case (ResultSrcW)
            2'b00: ResultW = ALUResultW;
            2'b01: ResultW = ReadDataW;
            2'b10: ResultW = PCPlus4W;
            2'b11: ResultW = ImmExtW;
        endcase
    end

    assign w_commit = RegWriteW && (RdW != '0) && !rst;

    // Decode must see a value in the same cycle it is written back.
    function automatic logic [DATA_WIDTH-1:0] f_read(input logic [REGISTER_ADDRESS_WIDTH-1:0] addr);
        if (rst || addr == '0)
            return '0;
        else if (w_commit && RdW == addr)
            return ResultW;
        else
            return r_regs[addr];
    endfunction

    always_comb begin
        RD1D = f_read(A1D);
        RD2D = f_read(A2D);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
            r_commit_count <= '0;
        end else begin
            if (w_commit)
                r_regs[RdW] <= ResultW;
            // Always re-assigned so the counter carries its current value forward every cycle.
            r_commit_count <= r_commit_count + {31'b0, w_commit};
        end
    end

    assign a0          = r_regs[10];
    assign CommitCount = r_commit_count;
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, ImmExtW, PCPlus4W;
    logic [4:0]  RdW, A1D, A2D;
    logic [31:0] ResultW, RD1D, RD2D, a0, CommitCount;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_WIDTH(32), .REGISTER_ADDRESS_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .ImmExtW(ImmExtW),
        .PCPlus4W(PCPlus4W), .RdW(RdW), .A1D(A1D), .A2D(A2D),
        .ResultW(ResultW), .RD1D(RD1D), .RD2D(RD2D), .a0(a0), .CommitCount(CommitCount)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_count;

    typedef struct {
        logic        rw;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [4:0]  rd, a1, a2;
        logic [31:0] e_res, e_rd1, e_rd2, e_a0, e_cnt;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_result();
        logic [31:0] sel [4];
        sel[0] = ALUResultW;
        sel[1] = ReadDataW;
        sel[2] = PCPlus4W;
        sel[3] = ImmExtW;
        return sel[ResultSrcW];
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (rst || a == 0) return 32'h0;
        if (RegWriteW && RdW == a) return m_result();
        return m_regs[a];
    endfunction

    task automatic set_in(input logic r, input logic rw, input logic [1:0] src, input logic [31:0] alu,
                          input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2);
        rst = r; RegWriteW = rw; ResultSrcW = src; ALUResultW = alu;
        ReadDataW = 32'h22; PCPlus4W = 32'h33; ImmExtW = 32'h44;
        RdW = rd; A1D = a1; A2D = a2;
        #2;
    endtask

    // Advance one clock edge and apply the architectural effect of the cycle to the model.
    task automatic tick();
        logic [31:0] res;
        logic        do_reset, do_commit;
        res       = m_result();
        do_reset  = rst;
        do_commit = RegWriteW && RdW != 0 && !rst;
        @(posedge clk);
        #1;
        if (do_reset) begin
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            m_count = 32'h0;
        end else if (do_commit) begin
            m_regs[RdW] = res;
            m_count     = m_count + 1;
        end
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = 32'h0;
        m_count = 32'h0;
        vecs[0]  = '{1'b1, 2'd0, 32'h11, 5'd1, 5'd1, 5'd0, 32'h11, 32'h11, 32'h0, 32'h0, 32'd1};
        vecs[1]  = '{1'b1, 2'd1, 32'h11, 5'd2, 5'd1, 5'd2, 32'h22, 32'h11, 32'h22, 32'h0, 32'd2};
        vecs[2]  = '{1'b1, 2'd2, 32'h11, 5'd3, 5'd3, 5'd1, 32'h33, 32'h33, 32'h11, 32'h0, 32'd3};
        vecs[3]  = '{1'b1, 2'd3, 32'h11, 5'd4, 5'd4, 5'd2, 32'h44, 32'h44, 32'h22, 32'h0, 32'd4};
        vecs[4]  = '{1'b1, 2'd0, 32'hDEADBEEF, 5'd0, 5'd0, 5'd4, 32'hDEADBEEF, 32'h0, 32'h44, 32'h0, 32'd4};
        vecs[5]  = '{1'b0, 2'd0, 32'h5, 5'd7, 5'd1, 5'd0, 32'h5, 32'h11, 32'h0, 32'h0, 32'd4};
        vecs[6]  = '{1'b1, 2'd0, 32'h5, 5'd7, 5'd7, 5'd7, 32'h5, 32'h5, 32'h5, 32'h0, 32'd5};
        vecs[7]  = '{1'b0, 2'd0, 32'h99, 5'd7, 5'd7, 5'd7, 32'h99, 32'h5, 32'h5, 32'h0, 32'd5};
        vecs[8]  = '{1'b1, 2'd0, 32'h99, 5'd7, 5'd7, 5'd7, 32'h99, 32'h99, 32'h99, 32'h0, 32'd6};
        vecs[9]  = '{1'b0, 2'd0, 32'h0, 5'd7, 5'd7, 5'd0, 32'h0, 32'h99, 32'h0, 32'h0, 32'd6};
        vecs[10] = '{1'b1, 2'd0, 32'hCAFE, 5'd10, 5'd10, 5'd0, 32'hCAFE, 32'hCAFE, 32'h0, 32'hCAFE, 32'd7};

        // Power-on reset.
        set_in(1'b1, 1'b0, 2'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        tick(); tick();
        chk("por_count", CommitCount, 32'h0);
        chk("por_a0", a0, 32'h0);

        // Preload x5, then reset with a write to x6 in flight.
        set_in(1'b0, 1'b1, 2'd0, 32'h1234, 5'd5, 5'd5, 5'd0);
        tick();
        chk("preload_count", CommitCount, 32'd1);
        set_in(1'b1, 1'b1, 2'd1, 32'h0, 5'd6, 5'd5, 5'd6);
        chk("rst_rd1", RD1D, 32'h0);
        chk("rst_rd2", RD2D, 32'h0);
        chk("rst_result_mux", ResultW, 32'h22);
        tick();
        chk("rst_count", CommitCount, 32'h0);
        chk("rst_a0", a0, 32'h0);
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 5'd0, 5'd5, 5'd6);
        chk("post_rst_x5", RD1D, 32'h0);
        chk("post_rst_x6", RD2D, 32'h0);

        // Directed vector table: result select, x0 protection, bypass, a0.
        for (int i = 0; i < 11; i++) begin
            set_in(1'b0, vecs[i].rw, vecs[i].src, vecs[i].alu, vecs[i].rd, vecs[i].a1, vecs[i].a2);
            chk($sformatf("vec%0d_result", i), ResultW, vecs[i].e_res);
            chk($sformatf("vec%0d_rd1", i), RD1D, vecs[i].e_rd1);
            chk($sformatf("vec%0d_rd2", i), RD2D, vecs[i].e_rd2);
            tick();
            chk($sformatf("vec%0d_a0", i), a0, vecs[i].e_a0);
            chk($sformatf("vec%0d_count", i), CommitCount, vecs[i].e_cnt);
        end

        // Reset asserted on the second of two back-to-back commits to x3.
        set_in(1'b0, 1'b1, 2'd0, 32'hAAA, 5'd3, 5'd3, 5'd0);
        tick();
        set_in(1'b1, 1'b1, 2'd0, 32'hBBB, 5'd3, 5'd3, 5'd3);
        chk("midrst_rd1", RD1D, 32'h0);
        tick();
        chk("midrst_count", CommitCount, 32'h0);
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 5'd3, 5'd3, 5'd10);
        chk("midrst_x3", RD1D, 32'h0);
        chk("midrst_x10", RD2D, 32'h0);
        set_in(1'b0, 1'b1, 2'd0, 32'hCCC, 5'd3, 5'd0, 5'd0);
        tick();
        chk("first_commit_count", CommitCount, 32'd1);
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 5'd0, 5'd3, 5'd0);
        chk("first_commit_x3", RD1D, 32'hCCC);

        // Counter wrap: preload the counter to all ones, then one commit.
        force dut.r_commit_count = 32'hFFFF_FFFF;
        tick();
        release dut.r_commit_count;
        #1;
        chk("wrap_preload", CommitCount, 32'hFFFF_FFFF);
        m_count = 32'hFFFF_FFFF;
        set_in(1'b0, 1'b1, 2'd2, 32'h0, 5'd9, 5'd9, 5'd0);
        tick();
        chk("wrap_count", CommitCount, 32'h0);

        // Randomized traffic against the architectural model.
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 40) == 0);
            RegWriteW  = $urandom_range(0, 3) != 0;
            ResultSrcW = 2'($urandom_range(0, 3));
            ALUResultW = $urandom;
            ReadDataW  = $urandom;
            PCPlus4W   = $urandom;
            ImmExtW    = $urandom;
            RdW        = 5'($urandom_range(0, 31));
            A1D        = ($urandom_range(0, 2) == 0) ? RdW : 5'($urandom_range(0, 31));
            A2D        = ($urandom_range(0, 2) == 0) ? RdW : 5'($urandom_range(0, 31));
            #2;
            chk("rand_result", ResultW, m_result());
            chk("rand_rd1", RD1D, m_read(A1D));
            chk("rand_rd2", RD2D, m_read(A2D));
            tick();
            chk("rand_a0", a0, m_regs[10]);
            chk("rand_count", CommitCount, m_count);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back end of the MEM/WB pipeline register. It takes the W-stage signals, selects the final result, and commits it to the 32 × 32-bit architectural register file. It also serves the two decode-stage read ports, with write-through bypass so that decode sees a value in the same cycle it is written back. It sits between the MEM/WB pipeline register and the decode stage. It exports x10 (a0) and a commit counter for test benches.

## Interface
Parameters:
- DATA_WIDTH, 32, register and result width
- REGISTER_ADDRESS_WIDTH, 5, register index width (2^5 = 32 registers)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- RegWriteW  input  1  write-back enable from MEM/WB register
- ResultSrcW  input  2  result select: 00 ALUResultW, 01 ReadDataW, 10 PCPlus4W, 11 ImmExtW
- ALUResultW  input  DATA_WIDTH  ALU result
- ReadDataW  input  DATA_WIDTH  load data
- ImmExtW  input  DATA_WIDTH  extended immediate (LUI path)
- PCPlus4W  input  DATA_WIDTH  link address (JAL/JALR)
- RdW  input  REGISTER_ADDRESS_WIDTH  destination register
- A1D  input  REGISTER_ADDRESS_WIDTH  decode read address 1 (rs1)
- A2D  input  REGISTER_ADDRESS_WIDTH  decode read address 2 (rs2)
- ResultW  output  DATA_WIDTH  selected write-back value (also drives the E-stage forwarding mux)
- RD1D  output  DATA_WIDTH  read data, port 1
- RD2D  output  DATA_WIDTH  read data, port 2
- a0  output  DATA_WIDTH  registered contents of x10
- CommitCount  output  32  number of committed register writes, wraps modulo 2^32

## Operation
- ResultW is a combinational 4:1 mux on ResultSrcW. It is valid regardless of RegWriteW.
- Commit condition: RegWriteW && (RdW != 0) && !rst.
  - When true, the register at index RdW is loaded with ResultW on the rising edge.
  - CommitCount is incremented by 1 on the same edge.
- Writes with RdW = 0:
  - Discarded; x0 always reads 0.
  - Do not increment CommitCount.
- Read ports are combinational, with the same rule applied independently to each port:
  - If rst is high, output 0.
  - Else if An = 0, output 0.
  - Else if the commit condition holds and RdW == An, output ResultW (bypass).
  - Else output the stored register value.
- Both ports may read the same register, and may hit the bypass simultaneously; both then return ResultW.
- a0 mirrors the stored x10 value, including a write committed on the previous edge. It has no bypass.
- CommitCount wraps from 0xFFFF_FFFF to 0x0000_0000 with no flag.

## Timing
- Reset:
  - On a rising edge with rst = 1, all 31 writable registers, a0 and CommitCount are cleared to 0.
  - A write presented in that cycle is dropped.
  - RD1D and RD2D read 0 while rst = 1.
  - ResultW stays a pure mux of its inputs.
- Reset asserted mid-stream: the in-flight W-stage write in the reset cycle is lost. The first commit after reset deasserts is counted as 1.
- Write latency: stored value updates at the edge ending the commit cycle. Through bypass, the read ports see the new value with zero cycles of latency.
- Read-after-write at the next edge: the stored value is returned with no bypass needed.
- No stalls or handshakes: every cycle with the commit condition true commits. Flush and bubble handling is upstream; a bubble arrives with RegWriteW = 0.

## Test plan
- Reset: preload x5 = 0x1234, assert rst for 1 cycle -> RD1D (A1D=5) = 0, a0 = 0, CommitCount = 0 after the edge.
- Result select: ALUResultW=0x11, ReadDataW=0x22, PCPlus4W=0x33, ImmExtW=0x44; sweep ResultSrcW 00..11 with RegWriteW=1, RdW=1..4 -> x1..x4 = 0x11, 0x22, 0x33, 0x44; CommitCount = 4.
- x0 protection: RegWriteW=1, RdW=0, ResultW=0xDEADBEEF -> RD1D (A1D=0) = 0 in the same and following cycles; CommitCount unchanged.
- Bypass: x7 holds 0x5; in one cycle RegWriteW=1, RdW=7, ALUResultW=0x99, A1D=A2D=7 -> RD1D = RD2D = 0x99 in that cycle and stored thereafter. Repeat with RegWriteW=0 -> RD1D = 0x5.
- a0 and wrap:
  - Write 0xCAFE to x10 -> a0 = 0xCAFE one edge later.
  - Force CommitCount to 0xFFFF_FFFF via repeated commits (or a bench-accessible preload), then one more commit -> CommitCount = 0.
- Reset mid-operation: commits to x3 on back-to-back cycles with rst asserted on the second -> x3 = 0, CommitCount = 0; the next commit gives CommitCount = 1.
